// File: rtl/cache_access_arbiter.sv
// cache_access_arbiter: per-channel request FIFOs feeding one registered output slot.
// Round-robin arbitration by default; define CACHE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module cache_access_arbiter #(
    parameter int CHANNELS     = 2,
    parameter int DEPTH        = 2,
    parameter int XLEN         = 32,
    parameter int CACHE_USER_W = 4
) (
    input  logic                                   clk_i,
    input  logic                                   arst_n,
    input  logic [CHANNELS-1:0][7:0]               in_id,
    input  logic [CHANNELS-1:0][XLEN-1:0]          in_addr,
    input  logic [CHANNELS-1:0][XLEN-1:0]          in_wdata,
    input  logic [CHANNELS-1:0]                    in_ci,
    input  logic [CHANNELS-1:0]                    in_wt,
    input  logic [CHANNELS-1:0][4:0]               in_opcode,
    input  logic [CHANNELS-1:0][9:0]               in_funct,
    input  logic [CHANNELS-1:0][CACHE_USER_W-1:0]  in_user,
    input  logic [CHANNELS-1:0][5:0]               in_error,
    input  logic [CHANNELS-1:0]                    in_valid,
    output logic [CHANNELS-1:0]                    in_full,
    output logic [7:0]                             out_id,
    output logic [XLEN-1:0]                        out_addr,
    output logic [XLEN-1:0]                        out_wdata,
    output logic                                   out_ci,
    output logic                                   out_wt,
    output logic [4:0]                             out_opcode,
    output logic [9:0]                             out_funct,
    output logic [CACHE_USER_W-1:0]                out_user,
    output logic [5:0]                             out_error,
    output logic [$clog2(CHANNELS)-1:0]            out_chan,
    output logic                                   out_valid,
    input  logic                                   out_full
);
    localparam int CW = $clog2(CHANNELS);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = 31 + 2 * XLEN + CACHE_USER_W;

    logic [PW-1:0]       mem_q [CHANNELS][DEPTH];
    logic [PW-1:0]       in_pl [CHANNELS];
    logic [AW-1:0]       wptr_q [CHANNELS];
    logic [AW-1:0]       rptr_q [CHANNELS];
    logic [AW:0]         cnt_q [CHANNELS];
    logic [CHANNELS-1:0] push, pop, nempty;
    logic [CW-1:0]       grant;
    logic                load;
    logic [PW-1:0]       out_q;
    logic                out_valid_q;
    logic [CW-1:0]       out_chan_q;
`ifndef CACHE_ARB_FIXED_PRIO_EN
    logic [CW-1:0]       last_grant_q;
    int                  idx;
`endif

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            in_pl[c]   = {in_id[c], in_addr[c], in_wdata[c], in_ci[c], in_wt[c],
                          in_opcode[c], in_funct[c], in_user[c], in_error[c]};
            in_full[c] = cnt_q[c] == (AW+1)'(DEPTH);
            push[c]    = in_valid[c] && !in_full[c];
            nempty[c]  = cnt_q[c] != '0;
        end
    end

    // Scan from the farthest candidate to the nearest so the highest-priority one is written last.
    always_comb begin
        grant = '0;
`ifdef CACHE_ARB_FIXED_PRIO_EN
        for (int i = CHANNELS - 1; i >= 0; i--)
            if (nempty[i]) grant = CW'(i);
`else
        idx = 0;
        for (int i = CHANNELS; i >= 1; i--) begin
            idx = (int'(last_grant_q) + i) % CHANNELS;
            if (nempty[idx]) grant = CW'(idx);
        end
`endif
    end

    assign load = (!out_valid_q || !out_full) && (|nempty);

    always_comb begin
        for (int c = 0; c < CHANNELS; c++)
            pop[c] = load && (grant == CW'(c));
    end

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < CHANNELS; c++)
            if (push[c]) mem_q[c][wptr_q[c]] <= in_pl[c];
    end

    always_ff @(posedge clk_i or negedge arst_n) begin
        if (!arst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (push[c]) wptr_q[c] <= wptr_q[c] + 1'b1;
                if (pop[c])  rptr_q[c] <= rptr_q[c] + 1'b1;
                cnt_q[c] <= cnt_q[c] + (AW+1)'(push[c]) - (AW+1)'(pop[c]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n) begin
        if (!arst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            out_chan_q   <= '0;
`ifndef CACHE_ARB_FIXED_PRIO_EN
            last_grant_q <= CW'(CHANNELS - 1);
`endif
        end else if (load) begin
            out_q        <= mem_q[grant][rptr_q[grant]];
            out_valid_q  <= 1'b1;
            out_chan_q   <= grant;
`ifndef CACHE_ARB_FIXED_PRIO_EN
            last_grant_q <= grant;
`endif
        end else if (out_valid_q && !out_full) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign {out_id, out_addr, out_wdata, out_ci, out_wt,
            out_opcode, out_funct, out_user, out_error} = out_q;
    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;
endmodule

// File: tb/tb_cache_access_arbiter.sv
// tb_cache_access_arbiter: directed checks of latency, arbitration order, back-pressure and reset.
module tb_cache_access_arbiter;
    localparam int CH = 2;
    localparam int XL = 32;
    localparam int UW = 4;

    logic                   clk_i = 1'b0;
    logic                   arst_n = 1'b0;
    logic [CH-1:0][7:0]     in_id = '0;
    logic [CH-1:0][XL-1:0]  in_addr = '0;
    logic [CH-1:0][XL-1:0]  in_wdata = '0;
    logic [CH-1:0]          in_ci = '0;
    logic [CH-1:0]          in_wt = '0;
    logic [CH-1:0][4:0]     in_opcode = '0;
    logic [CH-1:0][9:0]     in_funct = '0;
    logic [CH-1:0][UW-1:0]  in_user = '0;
    logic [CH-1:0][5:0]     in_error = '0;
    logic [CH-1:0]          in_valid = '0;
    logic [CH-1:0]          in_full;
    logic [7:0]             out_id;
    logic [XL-1:0]          out_addr;
    logic [XL-1:0]          out_wdata;
    logic                   out_ci;
    logic                   out_wt;
    logic [4:0]             out_opcode;
    logic [9:0]             out_funct;
    logic [UW-1:0]          out_user;
    logic [5:0]             out_error;
    logic [0:0]             out_chan;
    logic                   out_valid;
    logic                   out_full = 1'b0;

    int checks = 0;
    int errors = 0;

    cache_access_arbiter #(.CHANNELS(CH), .DEPTH(2), .XLEN(XL), .CACHE_USER_W(UW)) dut (
        .clk_i(clk_i), .arst_n(arst_n),
        .in_id(in_id), .in_addr(in_addr), .in_wdata(in_wdata), .in_ci(in_ci), .in_wt(in_wt),
        .in_opcode(in_opcode), .in_funct(in_funct), .in_user(in_user), .in_error(in_error),
        .in_valid(in_valid), .in_full(in_full),
        .out_id(out_id), .out_addr(out_addr), .out_wdata(out_wdata), .out_ci(out_ci), .out_wt(out_wt),
        .out_opcode(out_opcode), .out_funct(out_funct), .out_user(out_user), .out_error(out_error),
        .out_chan(out_chan), .out_valid(out_valid), .out_full(out_full)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic pulse_reset();
        arst_n = 1'b0;
        #2;
        arst_n = 1'b1;
    endtask

    logic [0:0] exp_chan [4];

    initial begin
`ifdef CACHE_ARB_FIXED_PRIO_EN
        exp_chan = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_chan = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_full", in_full, 0);
        check("rst_out_chan", out_chan, 0);
        check("rst_out_addr", out_addr, 0);
        arst_n = 1'b1;
        tick();

        // single request, latency 2
        in_valid = 2'b01; in_addr[0] = 32'h1000; in_id[0] = 8'h11; in_wdata[0] = 32'hDEADBEEF;
        in_user[0] = 4'h5; in_error[0] = 6'h2A; in_funct[0] = 10'h155; in_opcode[0] = 5'h13;
        tick();
        check("lat_c1_valid", out_valid, 0);
        in_valid = 2'b00;
        tick();
        check("lat_c2_valid", out_valid, 1);
        check("lat_c2_addr", out_addr, 32'h1000);
        check("lat_c2_chan", out_chan, 0);
        check("lat_c2_id", out_id, 8'h11);
        check("lat_c2_wdata", out_wdata, 32'hDEADBEEF);
        check("lat_c2_misc", {out_user, out_error, out_funct, out_opcode}, {4'h5, 6'h2A, 10'h155, 5'h13});
        tick();
        check("drain_valid", out_valid, 0);

        // both channels continuously valid
        pulse_reset();
        in_valid = 2'b11; in_addr[0] = 32'hA000; in_addr[1] = 32'hB000;
        tick();
        check("arb_c1_valid", out_valid, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("arb_valid%0d", i), out_valid, 1);
            check($sformatf("arb_chan%0d", i), out_chan, exp_chan[i]);
            check($sformatf("arb_addr%0d", i), out_addr, exp_chan[i] ? 32'hB000 : 32'hA000);
            tick();
        end
        in_valid = 2'b00;
        for (int i = 0; i < 8; i++) tick();
        check("arb_drained", out_valid, 0);

        // back-pressure on channel 1
        pulse_reset();
        out_full = 1'b1;
        in_valid = 2'b10; in_id[1] = 8'h3A;
        tick();
        check("bp_c1_full", in_full[1], 0);
        in_id[1] = 8'h3B;
        tick();
        check("bp_c2_full", in_full[1], 0);
        in_id[1] = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold_valid%0d", i), out_valid, 1);
            check($sformatf("hold_id%0d", i), out_id, 8'h3A);
            if (i > 0) check($sformatf("bp_full%0d", i), in_full[1], 1);
            if (i == 0) in_id[1] = 8'h3C; else in_id[1] = 8'h3D;
            tick();
        end
        check("bp_c7_full", in_full[1], 1);
        out_full = 1'b0;
        tick();
        check("rel_id_3B", out_id, 8'h3B);
        check("rel_full_clr", in_full[1], 0);
        tick();
        check("rel_id_3C", out_id, 8'h3C);
        in_valid = 2'b00;
        tick();
        check("rel_id_3D", out_id, 8'h3D);
        check("rel_chan", out_chan, 1);
        tick();
        check("rel_empty", out_valid, 0);

        // reset with buffered requests
        pulse_reset();
        out_full = 1'b1;
        in_valid = 2'b11; in_id[0] = 8'h50; in_id[1] = 8'h60;
        tick();
        in_id[0] = 8'h51; in_id[1] = 8'h61;
        tick();
        in_valid = 2'b00;
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_full", in_full, 2'b10);
        arst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_full", in_full, 0);
        check("arst_id", out_id, 0);
        #1;
        arst_n = 1'b1;
        out_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("post_rst_valid%0d", i), out_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_access_arbiter.md
CACHE_ACCESS_ARBITER -- requirements
Module: cache_access_arbiter

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of requesting cache-access channels (2..8).
REQ-002 SHALL have parameter DEPTH, default 2, per-channel request buffer entries (power of 2, >=2).
REQ-003 SHALL use one clock and one reset; the reset is asynchronous and active-low.
REQ-004 SHALL have port clk_i, input, 1, clock; all state on its rising edge.
REQ-005 SHALL have port arst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports in_id/in_addr/in_wdata/in_ci/in_wt/in_opcode/in_funct/in_user/in_error, input, CHANNELS x (8/XLEN/XLEN/1/1/5/10/CACHE_USER_W/6), per-channel request payload.
REQ-007 SHALL have port in_valid, input, CHANNELS, per-channel request valid.
REQ-008 SHALL have port in_full, output, CHANNELS, per-channel back-pressure; high means the request is not taken.
REQ-009 SHALL have ports out_id/out_addr/out_wdata/out_ci/out_wt/out_opcode/out_funct/out_user/out_error, output, same widths x1, granted payload.
REQ-010 SHALL have port out_chan, output, $clog2(CHANNELS), index of the channel owning the out payload.
REQ-011 SHALL have port out_valid, output, 1, out payload valid.
REQ-012 SHALL have port out_full, input, 1, downstream back-pressure.

Function
REQ-013 SHALL accept a channel request in a cycle where in_valid=1 and in_full=0; it is written to that channel's FIFO at the cycle end.
REQ-014 SHALL drive in_full[c] from a registered occupancy: 1 exactly when FIFO c holds DEPTH entries; dequeue in the same cycle does not clear it until the next cycle.
REQ-015 SHALL keep per-channel FIFO order; pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1.
REQ-016 SHALL hold one registered output slot; out_* change only when the slot loads.
REQ-017 SHALL load the slot when it is empty or drained this cycle (out_valid=1, out_full=0) and at least one FIFO is non-empty.
REQ-018 SHALL keep out_* stable while out_valid=1 and out_full=1.
REQ-019 SHALL give minimum latency 2: a request accepted in cycle C is visible on out_valid in C+2 at the earliest.
REQ-020 SHALL sustain one transfer per cycle when out_full=0 and requests are pending.
REQ-021 SHALL arbitrate round-robin: search starts at last_grant+1 modulo CHANNELS; last_grant updates only on slot load.
REQ-022 SHALL pass payload unmodified; out_chan carries the granted index.
REQ-023 SHALL clear out_valid when the slot drains and no FIFO is non-empty.
REQ-024 SHALL ignore in_valid when in_full=1; payload is not stored.
REQ-025 SHALL allow simultaneous enqueue and dequeue on one FIFO with count unchanged.

Reset
REQ-026 SHALL on arst_n=0 immediately clear all FIFO counts and pointers, out_valid=0, in_full=0, last_grant=CHANNELS-1, out_chan=0, and all out payload to 0.
REQ-027 SHALL discard buffered requests on reset mid-operation; no partial transfer survives.

Configuration
REQ-028 SHALL use macro CACHE_ARB_FIXED_PRIO_EN: defined -> fixed priority, lowest channel index wins, last_grant unused; undefined -> round-robin per REQ-021.

Verification
REQ-029 SHALL cover: CHANNELS=2, ch0 single request addr=0x1000 in cycle 0, out_full=0 -> out_valid=1, out_addr=0x1000, out_chan=0 in cycle 2.
REQ-030 SHALL cover: both channels continuously valid, out_full=0, round-robin -> out_chan sequence 0,1,0,1; with CACHE_ARB_FIXED_PRIO_EN -> 0,0,0,0 until ch0 stops.
REQ-031 SHALL cover: out_full=1, DEPTH=2, ch1 sends 4 requests -> 1 in slot, 2 buffered, in_full[1]=1 from the cycle after the 3rd accept; 4th held until release.
REQ-032 SHALL cover: out_full=1 for 5 cycles with slot loaded id=0x3A -> out_id stays 0x3A, out_valid stays 1 for all 5 cycles.
REQ-033 SHALL cover: arst_n pulsed low with 3 buffered requests -> out_valid=0, in_full=0 asynchronously, and no stale request emerges after release.
